bitwise8_bist: RTL and testbench
================================

BITWISE8_BIST -- requirements
Module: bitwise8_bist

Interface
REQ-001 SHALL have parameter NUM_VECTORS, default 16, total vectors per run (legal range 4..255).
REQ-002 SHALL have parameter SEED_A, default 8'hA5, LFSR seed for operand a.
REQ-003 SHALL have parameter SEED_B, default 8'h3C, LFSR seed for operand b.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, single-cycle run request.
REQ-007 SHALL have ports dut_a and dut_b, output, 8 each, operands driven to the 8-bit AND unit under test.
REQ-008 SHALL have port dut_y, input, 8, combinational result returned by the unit under test.
REQ-009 SHALL have ports busy, done and pass, output, 1 each, run status.
REQ-010 SHALL have port err_count, output, 8, count of mismatching vectors.
REQ-011 SHALL have ports fail_a, fail_b and fail_y, output, 8 each, first-failure capture (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, DRIVE, SAMPLE, FINISH.
REQ-013 SHALL transition IDLE->DRIVE on start=1 and clear err_count, vector index and capture registers on that edge.
REQ-014 SHALL, in DRIVE, hold dut_a/dut_b at the current vector and go to SAMPLE on the next cycle.
REQ-015 SHALL, in SAMPLE, compare dut_y against (dut_a & dut_b); on mismatch, err_count increments, saturating at 8'hFF.
REQ-016 SHALL, from SAMPLE, go to DRIVE with the next vector, or to FINISH when index == NUM_VECTORS-1.
REQ-017 SHALL use vectors 0..3 as fixed corners: (00,00), (FF,00), (AA,CC), (FF,FF); vectors 4.. come from the LFSRs.
REQ-018 SHALL use 8-bit Fibonacci LFSRs with taps 8,6,5,4, advanced once per SAMPLE->DRIVE transition from index >= 3; a zero seed SHALL be replaced by 8'h01.
REQ-019 SHALL complete a run in exactly 2*NUM_VECTORS cycles from start to FINISH entry.
REQ-020 SHALL assert busy in DRIVE and SAMPLE only, and assert done in FINISH only.
REQ-021 SHALL drive pass = done && (err_count == 0).
REQ-022 SHALL ignore start while busy; start in FINISH SHALL restart a run exactly as from IDLE.
REQ-023 SHALL drive dut_a/dut_b to 8'h00 in IDLE and FINISH.

Reset
REQ-024 SHALL, on rst=1, enter IDLE with all outputs 0, LFSRs reloaded from seeds; rst dominates start.
REQ-025 SHALL abort a run in progress on rst without asserting done.

Configuration
REQ-026 SHALL, with BIST_FAIL_CAPTURE_EN defined, latch dut_a, dut_b, dut_y of the first mismatching vector into fail_a/fail_b/fail_y, held until the next start or rst.
REQ-027 SHALL, without BIST_FAIL_CAPTURE_EN, tie fail_a, fail_b and fail_y to 8'h00 and generate no capture registers.

Structure
REQ-028 SHALL place state encodings, the four corner-vector constants and the LFSR tap mask in shared package bist_pkg.
REQ-029 SHALL implement the LFSR as sub-module lfsr8 (inputs clk, rst, load, seed, step; output q), instantiated twice.

Verification
REQ-030 SHALL cover: correct and8 connected, NUM_VECTORS=16, start pulse -> done at cycle 32, pass=1, err_count=0.
REQ-031 SHALL cover: DUT with y bit 0 stuck at 1 -> vector (00,00) fails first; with capture enabled, fail_a=00, fail_b=00, fail_y=01; err_count>0, pass=0.
REQ-032 SHALL cover: faulty DUT returning y=FF always, NUM_VECTORS=255 -> err_count=254 ((FF,FF) matches), no wrap.
REQ-033 SHALL cover: rst asserted at cycle 10 of a run -> next cycle IDLE, busy=0, done=0, err_count=0, dut_a=dut_b=00.
REQ-034 SHALL cover: start pulsed while busy -> run length unchanged; start in FINISH -> err_count cleared, new run of 2*NUM_VECTORS cycles.
REQ-035 SHALL cover: SEED_A=0 -> vector 4 a-operand is 8'h01; vector 1 observed on dut_a/dut_b as FF/00 in its DRIVE cycle.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and constants for the 8-bit AND built-in self test.
// Holds the FSM encoding, the four fixed corner vectors and the LFSR tap mask.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } bist_state_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
    } operand_pair_t;

    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3 of the shift register.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [7:0] CORNER0_A = 8'h00;
    localparam logic [7:0] CORNER0_B = 8'h00;
    localparam logic [7:0] CORNER1_A = 8'hFF;
    localparam logic [7:0] CORNER1_B = 8'h00;
    localparam logic [7:0] CORNER2_A = 8'hAA;
    localparam logic [7:0] CORNER2_B = 8'hCC;
    localparam logic [7:0] CORNER3_A = 8'hFF;
    localparam logic [7:0] CORNER3_B = 8'hFF;

    function automatic operand_pair_t corner_vector(input logic [1:0] idx);
        operand_pair_t v;
        case (idx)
            2'd0:    v = '{a: CORNER0_A, b: CORNER0_B};
            2'd1:    v = '{a: CORNER1_A, b: CORNER1_B};
            2'd2:    v = '{a: CORNER2_A, b: CORNER2_B};
            default: v = '{a: CORNER3_A, b: CORNER3_B};
        endcase
        return v;
    endfunction

    // Fibonacci step: shift left, feed back the parity of the tapped bits.
    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR operand source for the BIST.
// A zero seed would lock the register up, so it is replaced by 8'h01.
module lfsr8
    import bist_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    logic [7:0] seed_safe;

    assign seed_safe = (seed == 8'h00) ? 8'h01 : seed;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed_safe;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/bitwise8_bist.sv
// BIST controller for an external 8-bit AND unit: four corner vectors then LFSR vectors.
// Define BIST_FAIL_CAPTURE_EN to latch the operands and result of the first mismatch.
module bitwise8_bist
    import bist_pkg::*;
#(
    parameter int         NUM_VECTORS = 16,
    parameter logic [7:0] SEED_A      = 8'hA5,
    parameter logic [7:0] SEED_B      = 8'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] dut_a,
    output logic [7:0] dut_b,
    input  logic [7:0] dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] fail_a,
    output logic [7:0] fail_b,
    output logic [7:0] fail_y
);

    localparam logic [7:0] LAST_INDEX = 8'(NUM_VECTORS - 1);

    bist_state_t   state;
    bist_state_t   next_state;
    logic [7:0]    vec_index;
    logic          start_run;
    logic          advance;
    logic          step_lfsr;
    logic          mismatch;
    logic [7:0]    lfsr_a_q;
    logic [7:0]    lfsr_b_q;
    operand_pair_t next_corner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start is only honoured when no run is in flight.
    always_comb begin
        next_state = state;
        start_run  = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_run  = 1'b1;
                    next_state = DRIVE;
                end
            end
            DRIVE: begin
                next_state = SAMPLE;
            end
            SAMPLE: begin
                if (vec_index == LAST_INDEX) begin
                    next_state = FINISH;
                end else begin
                    advance    = 1'b1;
                    next_state = DRIVE;
                end
            end
            FINISH: begin
                if (start) begin
                    start_run  = 1'b1;
                    next_state = DRIVE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The operand registers take the LFSR value before it steps, so vector 4 is the seed itself.
    assign step_lfsr   = advance && (vec_index >= 8'd3);
    assign mismatch    = (state == SAMPLE) && (dut_y != (dut_a & dut_b));
    assign next_corner = corner_vector(2'(vec_index + 8'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_index <= 8'd0;
            dut_a     <= 8'h00;
            dut_b     <= 8'h00;
            err_count <= 8'h00;
        end else if (start_run) begin
            vec_index <= 8'd0;
            dut_a     <= CORNER0_A;
            dut_b     <= CORNER0_B;
            err_count <= 8'h00;
        end else begin
            if (mismatch && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (advance) begin
                vec_index <= vec_index + 8'd1;
                if (vec_index < 8'd3) begin
                    dut_a <= next_corner.a;
                    dut_b <= next_corner.b;
                end else begin
                    dut_a <= lfsr_a_q;
                    dut_b <= lfsr_b_q;
                end
            end else if (state == SAMPLE) begin
                dut_a <= 8'h00;
                dut_b <= 8'h00;
            end
        end
    end

    lfsr8 u_lfsr_a (
        .clk  (clk),
        .rst  (rst),
        .load (start_run),
        .seed (SEED_A),
        .step (step_lfsr),
        .q    (lfsr_a_q)
    );

    lfsr8 u_lfsr_b (
        .clk  (clk),
        .rst  (rst),
        .load (start_run),
        .seed (SEED_B),
        .step (step_lfsr),
        .q    (lfsr_b_q)
    );

`ifdef BIST_FAIL_CAPTURE_EN
    // A zero error count means this mismatch is the first one of the run.
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            fail_a <= 8'h00;
            fail_b <= 8'h00;
            fail_y <= 8'h00;
        end else if (mismatch && (err_count == 8'h00)) begin
            fail_a <= dut_a;
            fail_b <= dut_b;
            fail_y <= dut_y;
        end
    end
`else
    assign fail_a = 8'h00;
    assign fail_b = 8'h00;
    assign fail_y = 8'h00;
`endif

    assign busy = (state == DRIVE) || (state == SAMPLE);
    assign done = (state == FINISH);
    assign pass = done && (err_count == 8'h00);

endmodule

// File: tb/tb_bitwise8_bist.sv
// Scoreboard bench for bitwise8_bist: two instances (16 vectors, and 255 vectors with a zero SEED_A)
// driving a behavioural AND unit with selectable faults.
module tb_bitwise8_bist;

    localparam int N0 = 16;
    localparam int N1 = 255;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    typedef struct {
        logic [7:0] err;
        logic       pass;
        logic [7:0] fa;
        logic [7:0] fb;
        logic [7:0] fy;
        int         cycles;
    } result_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic [7:0] dut_a [2];
    logic [7:0] dut_b [2];
    logic [7:0] dut_y [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [7:0] err_count [2];
    logic [7:0] fail_a [2];
    logic [7:0] fail_b [2];
    logic [7:0] fail_y [2];
    int         mode [2];
    logic [7:0] flip_mask [2];

    vec_t    vec_q [2][$];
    result_t res_q [2][$];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Unit under test stand-in: 0 good AND, 1 bit0 stuck at 1, 2 always FF, 3 flip mask when a is odd.
    function automatic logic [7:0] fake_unit(input logic [7:0] a, input logic [7:0] b,
                                             input int m, input logic [7:0] mask);
        case (m)
            0:       return a & b;
            1:       return (a & b) | 8'h01;
            2:       return 8'hFF;
            default: return (a & b) ^ (a[0] ? mask : 8'h00);
        endcase
    endfunction

    assign dut_y[0] = fake_unit(dut_a[0], dut_b[0], mode[0], flip_mask[0]);
    assign dut_y[1] = fake_unit(dut_a[1], dut_b[1], mode[1], flip_mask[1]);

    bitwise8_bist #(.NUM_VECTORS(N0), .SEED_A(8'hA5), .SEED_B(8'h3C)) u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .dut_a(dut_a[0]), .dut_b(dut_b[0]), .dut_y(dut_y[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
        .fail_a(fail_a[0]), .fail_b(fail_b[0]), .fail_y(fail_y[0])
    );

    bitwise8_bist #(.NUM_VECTORS(N1), .SEED_A(8'h00), .SEED_B(8'h3C)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .dut_a(dut_a[1]), .dut_b(dut_b[1]), .dut_y(dut_y[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
        .fail_a(fail_a[1]), .fail_b(fail_b[1]), .fail_y(fail_y[1])
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, actual, actual, expected, expected, $time);
        end
    endtask

    task automatic reportFail(input string name);
        n_checks++;
        $display("[TB] FAIL %s at %0t", name, $time);
    endtask

    // Reference LFSR written as arithmetic: double modulo 256, add parity of bits 7,5,4,3.
    function automatic logic [7:0] ref_lfsr(input logic [7:0] x);
        int fb;
        fb = (int'(x[7]) + int'(x[5]) + int'(x[4]) + int'(x[3])) % 2;
        return 8'(((int'(x) * 2) % 256) + fb);
    endfunction

    // Builds the full vector list and final result of one run from the rules.
    task automatic modelRun(input int inst, input int n, input logic [7:0] sa, input logic [7:0] sb,
                            input int m, input logic [7:0] mask);
        logic [7:0] la, lb, a, b, y;
        int         errs;
        bit         have;
        result_t    r;
        la   = (sa == 8'h00) ? 8'h01 : sa;
        lb   = (sb == 8'h00) ? 8'h01 : sb;
        errs = 0;
        have = 0;
        r    = '{err: 8'h00, pass: 1'b0, fa: 8'h00, fb: 8'h00, fy: 8'h00, cycles: 2 * n};
        for (int k = 0; k < n; k++) begin
            case (k)
                0:       begin a = 8'h00; b = 8'h00; end
                1:       begin a = 8'hFF; b = 8'h00; end
                2:       begin a = 8'hAA; b = 8'hCC; end
                3:       begin a = 8'hFF; b = 8'hFF; end
                default: begin a = la; b = lb; la = ref_lfsr(la); lb = ref_lfsr(lb); end
            endcase
            vec_q[inst].push_back('{a: a, b: b});
            y = fake_unit(a, b, m, mask);
            if (y != (a & b)) begin
`ifdef BIST_FAIL_CAPTURE_EN
                if (!have) begin
                    r.fa = a;
                    r.fb = b;
                    r.fy = y;
                end
`endif
                have = 1;
                errs++;
            end
        end
        r.err  = (errs > 255) ? 8'hFF : 8'(errs);
        r.pass = (errs == 0);
        res_q[inst].push_back(r);
    endtask

    task automatic applyStimulus(input int inst, input int m);
        mode[inst]      = m;
        flip_mask[inst] = 8'($urandom_range(1, 255));
        if (inst == 0) modelRun(0, N0, 8'hA5, 8'h3C, m, flip_mask[0]);
        else           modelRun(1, N1, 8'h00, 8'h3C, m, flip_mask[1]);
        @(negedge clk);
        start[inst] = 1'b1;
        @(negedge clk);
        start[inst] = 1'b0;
    endtask

    task automatic waitDone(input int inst, input int budget);
        int k;
        k = 0;
        while (!done[inst] && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done[inst]) reportFail($sformatf("done timeout inst%0d", inst));
        @(negedge clk);
    endtask

    // Monitors: pop one vector per DRIVE cycle and one result when done rises.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        int bcnt      = 0;
        bit done_seen = 0;
        always @(negedge clk) begin
            if (busy[g] && done[g]) reportFail($sformatf("busy and done together inst%0d", g));
            if (busy[g]) begin
                if (bcnt % 2 == 0) begin
                    if (vec_q[g].size() == 0) begin
                        reportFail($sformatf("unexpected vector inst%0d", g));
                    end else begin
                        vec_t v;
                        v = vec_q[g].pop_front();
                        checkOutput($sformatf("dut_a inst%0d vec%0d", g, bcnt / 2), int'(dut_a[g]), int'(v.a));
                        checkOutput($sformatf("dut_b inst%0d vec%0d", g, bcnt / 2), int'(dut_b[g]), int'(v.b));
                    end
                end
                bcnt++;
            end else if (done[g] && !done_seen) begin
                done_seen = 1;
                if (res_q[g].size() == 0) begin
                    reportFail($sformatf("unexpected done inst%0d", g));
                end else begin
                    result_t r;
                    r = res_q[g].pop_front();
                    checkOutput($sformatf("err_count inst%0d", g), int'(err_count[g]), int'(r.err));
                    checkOutput($sformatf("pass inst%0d", g), int'(pass[g]), int'(r.pass));
                    checkOutput($sformatf("fail_a inst%0d", g), int'(fail_a[g]), int'(r.fa));
                    checkOutput($sformatf("fail_b inst%0d", g), int'(fail_b[g]), int'(r.fb));
                    checkOutput($sformatf("fail_y inst%0d", g), int'(fail_y[g]), int'(r.fy));
                    checkOutput($sformatf("run cycles inst%0d", g), bcnt, r.cycles);
                    checkOutput($sformatf("idle operands inst%0d", g), int'({dut_a[g], dut_b[g]}), 0);
                end
                bcnt = 0;
            end else if (!done[g]) begin
                bcnt = 0;
            end
            if (!done[g]) done_seen = 0;
        end
    end

    initial begin
        rst          = 1'b1;
        start[0]     = 1'b0;
        start[1]     = 1'b0;
        mode[0]      = 0;
        mode[1]      = 0;
        flip_mask[0] = 8'h00;
        flip_mask[1] = 8'h00;
        repeat (3) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        checkOutput("reset dominates start busy", int'(busy[0]), 0);
        start[0] = 1'b0;
        checkOutput("reset done", int'(done[0]), 0);
        checkOutput("reset pass", int'(pass[0]), 0);
        checkOutput("reset err_count", int'(err_count[0]), 0);
        checkOutput("reset operands", int'({dut_a[0], dut_b[0]}), 0);
        checkOutput("reset fail capture", int'({fail_a[0], fail_b[0], fail_y[0]}), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] good unit, 16 vectors");
        applyStimulus(0, 0);
        waitDone(0, 100);

        $display("[TB] bit0 stuck at 1, restart from FINISH");
        applyStimulus(0, 1);
        waitDone(0, 100);

        $display("[TB] randomized faults with ignored start pulses");
        for (int run = 0; run < 5; run++) begin
            applyStimulus(0, int'($urandom_range(0, 3)));
            repeat ($urandom_range(1, 20)) @(negedge clk);
            start[0] = 1'b1;
            @(negedge clk);
            start[0] = 1'b0;
            waitDone(0, 100);
        end

        $display("[TB] start in FINISH clears err_count");
        applyStimulus(0, 2);
        waitDone(0, 100);
        applyStimulus(0, 0);
        checkOutput("restart err_count cleared", int'(err_count[0]), 0);
        checkOutput("restart busy", int'(busy[0]), 1);
        waitDone(0, 100);

        $display("[TB] reset abort mid-run");
        applyStimulus(0, 2);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort busy", int'(busy[0]), 0);
        checkOutput("abort done", int'(done[0]), 0);
        checkOutput("abort err_count", int'(err_count[0]), 0);
        checkOutput("abort operands", int'({dut_a[0], dut_b[0]}), 0);
        vec_q[0].delete();
        res_q[0].delete();
        repeat (40) @(negedge clk);
        checkOutput("abort stays idle", int'({busy[0], done[0]}), 0);

        $display("[TB] 255 vectors, zero SEED_A");
        applyStimulus(1, 0);
        waitDone(1, 600);
        applyStimulus(1, 2);
        waitDone(1, 600);
        checkOutput("all-FF unit err_count", int'(err_count[1]), 254);

        repeat (3) @(negedge clk);
        checkOutput("vector queue drained", vec_q[0].size() + vec_q[1].size(), 0);
        checkOutput("result queue drained", res_q[0].size() + res_q[1].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
